// File: rtl/yuu_common_sync_fifo.sv
// rtl/yuu_common_sync_fifo.sv - parametrised single-clock FIFO with show-ahead or registered read
module yuu_common_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2,
  parameter bit SHOW_AHEAD = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance is judged against the registered full/empty, so there is no
  // same-cycle pass-through and no combinational path into the flags.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Status flags are plain decodes of the occupancy register.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AFULL_TH));
  assign almost_empty = (count <= CW'(AEMPTY_TH));

  // Storage write; contents survive clr and rst by design.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  generate
    if (SHOW_AHEAD) begin : g_show_ahead
      // Head word is presented directly; gated to zero while empty so the
      // output is defined after reset and does not expose stale entries.
      assign rd_data  = empty ? '0 : mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      // Registered read: capture the head on an accepted pop, pulse valid once.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (clr) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_yuu_common_sync_fifo.sv
// tb/tb_yuu_common_sync_fifo.sv - scoreboard bench driving a show-ahead and a registered FIFO in lockstep
module tb_yuu_common_sync_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;

  logic [31:0] fa_rd_data, rg_rd_data;
  logic        fa_rd_valid, rg_rd_valid;
  logic        fa_full, rg_full, fa_empty, rg_empty;
  logic        fa_afull, rg_afull, fa_aempty, rg_aempty;
  logic [4:0]  fa_count, rg_count;
  logic        fa_ovf, rg_ovf, fa_unf, rg_unf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_count;
  logic        m_ovf, m_unf;
  logic [31:0] q_fa[$];
  logic [31:0] q_rg[$];
  logic        pend_v;
  logic [31:0] rg_hold;

  always #5 clk = ~clk;

  yuu_common_sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .SHOW_AHEAD(1'b1)) u_fa (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(fa_rd_data), .rd_valid(fa_rd_valid), .full(fa_full), .empty(fa_empty),
    .almost_full(fa_afull), .almost_empty(fa_aempty), .count(fa_count),
    .overflow(fa_ovf), .underflow(fa_unf)
  );

  yuu_common_sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4),
                         .SHOW_AHEAD(1'b0)) u_rg (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rg_rd_data), .rd_valid(rg_rd_valid), .full(rg_full), .empty(rg_empty),
    .almost_full(rg_afull), .almost_empty(rg_aempty), .count(rg_count),
    .overflow(rg_ovf), .underflow(rg_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    q_fa.delete();
    q_rg.delete();
    pend_v  = 1'b0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":fa_count"},  32'(fa_count), 32'(m_count));
    chk({ctx, ":rg_count"},  32'(rg_count), 32'(m_count));
    chk({ctx, ":fa_empty"},  32'(fa_empty), 32'(m_count == 0));
    chk({ctx, ":fa_full"},   32'(fa_full),  32'(m_count == 16));
    chk({ctx, ":rg_empty"},  32'(rg_empty), 32'(m_count == 0));
    chk({ctx, ":rg_full"},   32'(rg_full),  32'(m_count == 16));
    chk({ctx, ":fa_afull"},  32'(fa_afull), 32'(m_count >= 14));
    chk({ctx, ":fa_aempty"}, 32'(fa_aempty), 32'(m_count <= 2));
    chk({ctx, ":rg_afull"},  32'(rg_afull), 32'(m_count >= 12));
    chk({ctx, ":rg_aempty"}, 32'(rg_aempty), 32'(m_count <= 4));
    chk({ctx, ":fa_ovf"},    32'(fa_ovf), 32'(m_ovf));
    chk({ctx, ":fa_unf"},    32'(fa_unf), 32'(m_unf));
    chk({ctx, ":rg_ovf"},    32'(rg_ovf), 32'(m_ovf));
    chk({ctx, ":rg_unf"},    32'(rg_unf), 32'(m_unf));
    chk({ctx, ":fa_rd_valid"}, 32'(fa_rd_valid), 32'(m_count > 0));
    if (m_count > 0) chk({ctx, ":fa_rd_data"}, fa_rd_data, q_fa[0]);
    chk({ctx, ":rg_rd_valid"}, 32'(rg_rd_valid), 32'(pend_v));
    chk({ctx, ":rg_rd_data"},  rg_rd_data, rg_hold);
  endtask

  // One clock cycle: called at a negedge, drives inputs, advances the model
  // at the posedge and checks outputs at the following negedge.
  task automatic cyc(input logic w, input logic [31:0] d, input logic r, input logic c,
                     input string ctx);
    logic wa, ra;
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    wa = w && (m_count < 16);
    ra = r && (m_count > 0);
    @(posedge clk);
    if (c) begin
      m_count = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      q_fa.delete();
      q_rg.delete();
      pend_v  = 1'b0;
    end else begin
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_unf = 1'b1;
      pend_v = ra;
      if (ra) begin
        void'(q_fa.pop_front());
        rg_hold = q_rg.pop_front();
      end
      if (wa) begin
        q_fa.push_back(d);
        q_rg.push_back(d);
      end
      m_count = m_count + (wa ? 1 : 0) - (ra ? 1 : 0);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    rg_hold = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // Asynchronous reset in the middle of a cycle with count=5
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100 + i, 1'b0, 1'b0, "pre_rst");
    #2 rst = 1'b1;
    #1;
    model_reset();
    rg_hold = '0;
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("post_rst");

    // Fill 0x00..0x0F, then a 17th write while full
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, "fill");
    cyc(1'b1, 32'hAA, 1'b0, 1'b0, "overflow");
    // Both requested while full: only the read is taken
    cyc(1'b1, 32'hBB, 1'b1, 1'b0, "full_rw");
    for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1, 1'b0, "drain");
    cyc(1'b0, '0, 1'b1, 1'b0, "underflow");
    // clr with requests present: requests ignored, flags cleared
    cyc(1'b1, 32'hCC, 1'b1, 1'b1, "clr");
    // Both requested while empty: only the write is taken
    cyc(1'b1, 32'hDD, 1'b1, 1'b0, "empty_rw");
    cyc(1'b0, '0, 1'b0, 1'b1, "clr2");

    // Both requested at count=8
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h200 + i, 1'b0, 1'b0, "to8");
    cyc(1'b1, 32'h2FF, 1'b1, 1'b0, "mid_rw");
    cyc(1'b0, '0, 1'b0, 1'b1, "clr3");

    // Streaming through several pointer wraps at count=3
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + i, 1'b0, 1'b0, "pre_stream");
    for (int i = 3; i < 43; i++) cyc(1'b1, 32'h300 + i, 1'b1, 1'b0, "stream");
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, "post_stream");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
